// File: rtl/id_ex_pkg.sv
// id_ex_pkg: shared definitions for the ID/EX pipeline register.
//   - CTRL_W and bit positions of the decoded control word
//     ctrl = {alu_src, reg_dest, mem_wr, mem_rd, reg_wr, mem_to_reg}
//   - default operand widths and a packed entry typedef at those widths
//   - ctrl_is_load(): true when a control word describes a memory read
// Optional feature macro used by the importing RTL: LOAD_USE_STALL_EN.
package id_ex_pkg;

    localparam int CTRL_W         = 6;
    localparam int CTRL_MEM_TO_REG = 0;
    localparam int CTRL_REG_WR     = 1;
    localparam int CTRL_MEM_RD     = 2;
    localparam int CTRL_MEM_WR     = 3;
    localparam int CTRL_REG_DEST   = 4;
    localparam int CTRL_ALU_SRC    = 5;

    localparam int ID_EX_DATA_W  = 32;
    localparam int ID_EX_REG_AW  = 5;
    localparam int ID_EX_ALUOP_W = 6;

    // Entry layout at the default core widths; modules with other widths
    // declare the same field order locally from their own parameters.
    typedef struct packed {
        logic [ID_EX_DATA_W-1:0]  rd1;
        logic [ID_EX_DATA_W-1:0]  rd2;
        logic [ID_EX_DATA_W-1:0]  imm;
        logic [ID_EX_REG_AW-1:0]  rs;
        logic [ID_EX_REG_AW-1:0]  rt;
        logic [ID_EX_REG_AW-1:0]  rd;
        logic [ID_EX_ALUOP_W-1:0] alu_op;
        logic [CTRL_W-1:0]        ctrl;
    } id_ex_entry_t;

    function automatic logic ctrl_is_load(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CTRL_MEM_RD];
    endfunction

endpackage

// File: rtl/id_ex_skid_slot.sv
// id_ex_skid_slot: one held pipeline entry (payload register + valid bit).
// Ports:
//   clk, rst      clock, synchronous active-high reset (clears valid and payload)
//   i_load        capture i_data and take valid from i_valid
//   i_valid       valid value written on i_load
//   i_clear       drop valid, payload kept (ignored when i_load is set)
//   i_data        payload to capture
//   o_valid       entry valid
//   o_data        held payload
module id_ex_skid_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_valid,
    input  logic         i_clear,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // Entry storage: reset > load > clear > hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= {W{1'b0}};
        end else if (i_load) begin
            r_valid <= i_valid;
            r_data  <= i_data;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX pipeline register with valid/ready handshake,
// a two-entry (main + skid) buffer and flush with NOP bubble insertion.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   flush                  drop every held entry and the input of this cycle
//   in_valid / in_ready    decode-side handshake
//   rd1_i rd2_i imm_i      operands / sign-extended immediate (DATA_W)
//   rs_i rt_i rd_i         register indices (REG_AW)
//   alu_op_i, ctrl_i       ALU opcode, control word
//   out_valid / out_ready  EX-side handshake
//   *_o                    payload of the main entry (registered)
//   hazard_o               load-use stall indicator
// Optional feature: define LOAD_USE_STALL_EN to stall a consumer of a load
// held in this stage; otherwise hazard_o is tied low.
module id_ex_pipe_reg
    import id_ex_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  rd1_i,
    input  logic [DATA_W-1:0]  rd2_i,
    input  logic [DATA_W-1:0]  imm_i,
    input  logic [REG_AW-1:0]  rs_i,
    input  logic [REG_AW-1:0]  rt_i,
    input  logic [REG_AW-1:0]  rd_i,
    input  logic [ALUOP_W-1:0] alu_op_i,
    input  logic [CTRL_W-1:0]  ctrl_i,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  rd1_o,
    output logic [DATA_W-1:0]  rd2_o,
    output logic [DATA_W-1:0]  imm_o,
    output logic [REG_AW-1:0]  rs_o,
    output logic [REG_AW-1:0]  rt_o,
    output logic [REG_AW-1:0]  rd_o,
    output logic [ALUOP_W-1:0] alu_op_o,
    output logic [CTRL_W-1:0]  ctrl_o,
    output logic               hazard_o
);

    typedef struct packed {
        logic [DATA_W-1:0]  rd1;
        logic [DATA_W-1:0]  rd2;
        logic [DATA_W-1:0]  imm;
        logic [REG_AW-1:0]  rs;
        logic [REG_AW-1:0]  rt;
        logic [REG_AW-1:0]  rd;
        logic [ALUOP_W-1:0] alu_op;
        logic [CTRL_W-1:0]  ctrl;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    entry_t w_in;
    entry_t w_main;
    entry_t w_skid;
    entry_t w_bubble;
    entry_t w_main_d;
    logic   w_main_v;
    logic   w_skid_v;
    logic   w_main_load;
    logic   w_main_valid_d;
    logic   w_skid_load;
    logic   w_skid_clear;
    logic   w_main_adv;
    logic   w_accept;
    logic   w_hazard;

    assign w_in = {rd1_i, rd2_i, imm_i, rs_i, rt_i, rd_i, alu_op_i, ctrl_i};

`ifdef LOAD_USE_STALL_EN
    entry_t w_young;
    logic   w_young_v;

    // Youngest held entry: the skid slot always holds the newer instruction.
    always_comb begin
        if (w_skid_v) begin
            w_young = w_skid;
        end else begin
            w_young = w_main;
        end
    end

    assign w_young_v = w_skid_v || w_main_v;
    assign w_hazard  = !rst && in_valid && w_young_v && ctrl_is_load(w_young.ctrl) &&
                       (w_young.rt != {REG_AW{1'b0}}) &&
                       ((w_young.rt == rs_i) || (w_young.rt == rt_i));
`else
    assign w_hazard = 1'b0;
`endif

    // Inputs are refused whenever the skid slot is occupied, so nothing can
    // ever need a third storage place.
    assign in_ready   = !w_skid_v && !rst && !w_hazard;
    assign w_accept   = in_valid && in_ready;
    assign w_main_adv = !w_main_v || out_ready;

    // Empty main entry: keep the data fields, zero opcode and control so EX sees a NOP.
    always_comb begin
        w_bubble        = w_main;
        w_bubble.alu_op = {ALUOP_W{1'b0}};
        w_bubble.ctrl   = {CTRL_W{1'b0}};
    end

    // Next-state selection for the main and skid slots.
    always_comb begin
        w_main_load    = 1'b0;
        w_main_valid_d = 1'b0;
        w_main_d       = w_bubble;
        w_skid_load    = 1'b0;
        w_skid_clear   = 1'b0;
        if (flush) begin
            w_main_load  = 1'b1;
            w_skid_clear = 1'b1;
        end else if (w_main_adv) begin
            w_main_load = 1'b1;
            if (w_skid_v) begin
                w_main_valid_d = 1'b1;
                w_main_d       = w_skid;
                w_skid_load    = w_accept;
                w_skid_clear   = !w_accept;
            end else if (w_accept) begin
                w_main_valid_d = 1'b1;
                w_main_d       = w_in;
            end else begin
                w_main_valid_d = 1'b0;
            end
        end else begin
            // Main is stalled: a newly accepted entry parks in the skid slot.
            w_skid_load = w_accept;
        end
    end

    id_ex_skid_slot #(.W(ENTRY_W)) u_main (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_main_load),
        .i_valid (w_main_valid_d),
        .i_clear (1'b0),
        .i_data  (w_main_d),
        .o_valid (w_main_v),
        .o_data  (w_main)
    );

    id_ex_skid_slot #(.W(ENTRY_W)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_skid_load),
        .i_valid (1'b1),
        .i_clear (w_skid_clear),
        .i_data  (w_in),
        .o_valid (w_skid_v),
        .o_data  (w_skid)
    );

    assign out_valid = w_main_v;
    assign rd1_o     = w_main.rd1;
    assign rd2_o     = w_main.rd2;
    assign imm_o     = w_main.imm;
    assign rs_o      = w_main.rs;
    assign rt_o      = w_main.rt;
    assign rd_o      = w_main.rd;
    assign alu_op_o  = w_main.alu_op;
    assign ctrl_o    = w_main.ctrl;
    assign hazard_o  = w_hazard;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
module tb_id_ex_pipe_reg;

    localparam int MEM_RD_BIT = 2;

    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  alu_op;
        logic [5:0]  ctrl;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] rd1_i = 32'h0, rd2_i = 32'h0, imm_i = 32'h0;
    logic [4:0]  rs_i = 5'h0, rt_i = 5'h0, rd_i = 5'h0;
    logic [5:0]  alu_op_i = 6'h0, ctrl_i = 6'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] rd1_o, rd2_o, imm_o;
    logic [4:0]  rs_o, rt_o, rd_o;
    logic [5:0]  alu_op_o, ctrl_o;
    logic        hazard_o;

    int n_checks = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    // Model: the entries the stage currently holds, oldest first.
    ent_t q[$];

    id_ex_pipe_reg dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .rd1_i(rd1_i), .rd2_i(rd2_i), .imm_i(imm_i),
        .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i),
        .alu_op_i(alu_op_i), .ctrl_i(ctrl_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .rd1_o(rd1_o), .rd2_o(rd2_o), .imm_o(imm_o),
        .rs_o(rs_o), .rt_o(rt_o), .rd_o(rd_o),
        .alu_op_o(alu_op_o), .ctrl_o(ctrl_o),
        .hazard_o(hazard_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic ent_t mk(input int n);
        ent_t e;
        e.rd1    = 32'h1000_0000 + 32'(n);
        e.rd2    = 32'h2000_0000 + 32'(n);
        e.imm    = 32'h0000_0100 + 32'(n);
        e.rs     = 5'(n * 3 + 1);
        e.rt     = 5'(n * 5 + 2);
        e.rd     = 5'(n);
        e.alu_op = {1'b1, 5'(n)};
        e.ctrl   = 6'b010010 ^ {3'(n), 3'b000};
        return e;
    endfunction

    function automatic ent_t cur_in();
        ent_t e;
        e = {rd1_i, rd2_i, imm_i, rs_i, rt_i, rd_i, alu_op_i, ctrl_i};
        return e;
    endfunction

    function automatic bit model_hazard();
`ifdef LOAD_USE_STALL_EN
        ent_t y;
        if (q.size() == 0) return 1'b0;
        y = q[q.size() - 1];
        return in_valid && y.ctrl[MEM_RD_BIT] && (y.rt != 5'd0) && (y.rt == rs_i || y.rt == rt_i);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit exp_ready();
        return !rst && (q.size() < 2) && !model_hazard();
    endfunction

    // Model update at the active edge from the inputs of the closing cycle.
    always @(posedge clk) begin
        if (rst || flush) begin
            q.delete();
        end else if (in_valid && exp_ready()) begin
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            q.push_back(cur_in());
        end else if (q.size() > 0 && out_ready) begin
            void'(q.pop_front());
        end
    end

    // Compare process: every falling edge, outputs against the model.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
            chk("in_ready", 64'(in_ready), 64'(exp_ready()));
            chk("hazard_o", 64'(hazard_o), 64'(model_hazard()));
            if (q.size() > 0) begin
                chk("rd1_o", 64'(rd1_o), 64'(q[0].rd1));
                chk("rd2_o", 64'(rd2_o), 64'(q[0].rd2));
                chk("imm_o", 64'(imm_o), 64'(q[0].imm));
                chk("rs_o", 64'(rs_o), 64'(q[0].rs));
                chk("rt_o", 64'(rt_o), 64'(q[0].rt));
                chk("rd_o", 64'(rd_o), 64'(q[0].rd));
                chk("alu_op_o", 64'(alu_op_o), 64'(q[0].alu_op));
                chk("ctrl_o", 64'(ctrl_o), 64'(q[0].ctrl));
            end else begin
                chk("bubble_ctrl", 64'(ctrl_o), 64'h0);
                chk("bubble_alu_op", 64'(alu_op_o), 64'h0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        @(negedge clk);
        #1;
    endtask

    task automatic drv(input ent_t e);
        in_valid = 1'b1;
        rd1_i = e.rd1; rd2_i = e.rd2; imm_i = e.imm;
        rs_i = e.rs; rt_i = e.rt; rd_i = e.rd;
        alu_op_i = e.alu_op; ctrl_i = e.ctrl;
    endtask

    initial begin
        ent_t e;

        // 1: reset
        step();
        mon_en = 1'b1;
        step();
        probe();
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_ctrl_o", 64'(ctrl_o), 64'h0);
        chk("rst_rd1_o", 64'(rd1_o), 64'h0);
        chk("rst_in_ready", 64'(in_ready), 64'h0);
        chk("rst_hazard_o", 64'(hazard_o), 64'h0);
        rst = 1'b0;
        probe();
        chk("post_rst_in_ready", 64'(in_ready), 64'h1);

        // 2: stream of 8 with EX always ready
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drv(mk(i));
            step();
            chk("stream_valid", 64'(out_valid), 64'h1);
            chk("stream_rd1", 64'(rd1_o), 64'(32'h1000_0000 + 32'(i)));
        end
        in_valid = 1'b0;
        step();

        // 3: stall with A, B, C offered
        out_ready = 1'b0;
        drv(mk(10));
        step();
        drv(mk(11));
        step();
        drv(mk(12));
        probe();
        chk("stall_valid", 64'(out_valid), 64'h1);
        chk("stall_rd1_A", 64'(rd1_o), 64'h1000_000A);
        chk("stall_in_ready", 64'(in_ready), 64'h0);
        step();
        out_ready = 1'b1;
        step();
        probe();
        chk("stall_rd1_B", 64'(rd1_o), 64'h1000_000B);
        step();
        in_valid = 1'b0;
        probe();
        chk("stall_rd1_C", 64'(rd1_o), 64'h1000_000C);
        step();

        // 4: flush with main and skid full and an input offered
        out_ready = 1'b0;
        drv(mk(13));
        step();
        drv(mk(14));
        step();
        drv(mk(15));
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        probe();
        chk("flush_out_valid", 64'(out_valid), 64'h0);
        chk("flush_ctrl_o", 64'(ctrl_o), 64'h0);
        chk("flush_in_ready", 64'(in_ready), 64'h1);
        out_ready = 1'b1;

`ifdef LOAD_USE_STALL_EN
        // 5: load-use stall: lw rt=8 then consumer rs=8
        e = mk(20);
        e.ctrl = 6'b100111;
        e.rt = 5'd8;
        drv(e);
        step();
        e = mk(21);
        e.rs = 5'd8;
        e.rt = 5'd3;
        drv(e);
        probe();
        chk("lu_hazard", 64'(hazard_o), 64'h1);
        chk("lu_in_ready", 64'(in_ready), 64'h0);
        step();
        probe();
        chk("lu_bubble_valid", 64'(out_valid), 64'h0);
        chk("lu_bubble_ctrl", 64'(ctrl_o), 64'h0);
        chk("lu_hazard_clear", 64'(hazard_o), 64'h0);
        step();
        in_valid = 1'b0;
        probe();
        chk("lu_consumer_valid", 64'(out_valid), 64'h1);
        chk("lu_consumer_rd1", 64'(rd1_o), 64'h1000_0015);
        step();
`endif

        // 6: load with rt=0 followed by a reader of r0: no stall
        e = mk(30);
        e.ctrl = 6'b100111;
        e.rt = 5'd0;
        drv(e);
        step();
        e = mk(31);
        e.rs = 5'd0;
        e.rt = 5'd0;
        drv(e);
        probe();
        chk("r0_hazard", 64'(hazard_o), 64'h0);
        chk("r0_in_ready", 64'(in_ready), 64'h1);
        step();
        in_valid = 1'b0;
        probe();
        chk("r0_valid", 64'(out_valid), 64'h1);
        chk("r0_rd1", 64'(rd1_o), 64'h1000_001F);
        step();

        // Mixed traffic: irregular valid/ready, loads, one flush, model-checked.
        for (int i = 0; i < 48; i++) begin
            e = mk(100 + i);
            e.ctrl[MEM_RD_BIT] = i[0];
            e.rs = 5'(i % 5);
            e.rt = 5'((i + 2) % 5);
            drv(e);
            in_valid  = (i % 4 != 3);
            out_ready = (i % 3 != 0);
            flush     = (i == 17);
            step();
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
